// File: rtl/disc_layer2_arbiter.sv
// Two-requester round-robin front end for the shared layer-2 engine.
// One job at a time: accept a request, pulse the engine, wait for done or
// timeout, then hold the response until the owning requester takes it.
module disc_layer2_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16384,
    localparam int unsigned IN_W  = 2048,
    localparam int unsigned OUT_W = 512
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic signed [IN_W-1:0]  req0_data,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic signed [IN_W-1:0]  req1_data,
    output logic                    resp0_valid,
    input  logic                    resp0_ready,
    output logic signed [OUT_W-1:0] resp0_data,
    output logic                    resp0_err,
    output logic                    resp1_valid,
    input  logic                    resp1_ready,
    output logic signed [OUT_W-1:0] resp1_data,
    output logic                    resp1_err,
    output logic                    layer_start,
    output logic [IN_W-1:0]         layer_input,
    input  logic [OUT_W-1:0]        layer_output,
    input  logic                    layer_done,
    output logic                    busy,
    output logic                    grant_id,
    output logic                    timeout_err
);

    // Wait counter is at least 15 bits, wider only if the timeout needs it.
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES) > 15) ? $clog2(TIMEOUT_CYCLES) : 15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t           state;
    logic             rr_ptr;      // requester that wins a tie
    logic [CNT_W-1:0] wait_cnt;
    logic             win_c;
    logic             take_c;
    logic             timeout_hit_c;
    logic             resp_hs_c;

    // Round-robin winner among the currently valid requesters, only offered in IDLE.
    always_comb begin
        win_c = rr_ptr;
        if (req0_valid && !req1_valid) begin
            win_c = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            win_c = 1'b1;
        end
        take_c        = (state == ST_IDLE) && !rst && (req0_valid || req1_valid);
        timeout_hit_c = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
        resp_hs_c     = (state == ST_RESP) && (grant_id ? resp1_ready : resp0_ready);
    end

    assign req0_ready = take_c && !win_c;
    assign req1_ready = take_c && win_c;

    // Job sequencing: accept, start pulse, wait for done/timeout, hold response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            rr_ptr      <= 1'b0;
            wait_cnt    <= '0;
            grant_id    <= 1'b0;
            layer_input <= '0;
            layer_start <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            resp0_valid <= 1'b0;
            resp0_data  <= '0;
            resp0_err   <= 1'b0;
            resp1_valid <= 1'b0;
            resp1_data  <= '0;
            resp1_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (take_c) begin
                        layer_input <= win_c ? req1_data : req0_data;
                        grant_id    <= win_c;
                        rr_ptr      <= ~win_c;
                        layer_start <= 1'b1;
                        busy        <= 1'b1;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    layer_start <= 1'b0;
                    wait_cnt    <= '0;
                    state       <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Done wins over a timeout landing on the same cycle.
                    if (layer_done) begin
                        if (grant_id) begin
                            resp1_data  <= layer_output;
                            resp1_err   <= 1'b0;
                            resp1_valid <= 1'b1;
                        end else begin
                            resp0_data  <= layer_output;
                            resp0_err   <= 1'b0;
                            resp0_valid <= 1'b1;
                        end
                        state <= ST_RESP;
                    end else if (timeout_hit_c) begin
                        timeout_err <= 1'b1;
                        if (grant_id) begin
                            resp1_data  <= '0;
                            resp1_err   <= 1'b1;
                            resp1_valid <= 1'b1;
                        end else begin
                            resp0_data  <= '0;
                            resp0_err   <= 1'b1;
                            resp0_valid <= 1'b1;
                        end
                        state <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (resp_hs_c) begin
                        resp0_valid <= 1'b0;
                        resp1_valid <= 1'b0;
                        resp0_err   <= 1'b0;
                        resp1_err   <= 1'b0;
                        busy        <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_disc_layer2_arbiter.sv
// Directed bench for disc_layer2_arbiter. Instance a uses the default timeout,
// instance b a 64-cycle timeout; the idle instance is held in reset and the
// checked outputs are muxed from the active one.
module tb_disc_layer2_arbiter;

    localparam int unsigned IN_W  = 2048;
    localparam int unsigned OUT_W = 512;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, use_b;
    logic req0_valid, req1_valid, resp0_ready, resp1_ready, layer_done;
    logic signed [IN_W-1:0] req0_data, req1_data;
    logic [OUT_W-1:0] layer_output;

    logic a_req0_ready, a_req1_ready, a_resp0_valid, a_resp1_valid, a_resp0_err, a_resp1_err;
    logic a_layer_start, a_busy, a_grant_id, a_timeout_err;
    logic signed [OUT_W-1:0] a_resp0_data, a_resp1_data;
    logic [IN_W-1:0] a_layer_input;

    logic b_req0_ready, b_req1_ready, b_resp0_valid, b_resp1_valid, b_resp0_err, b_resp1_err;
    logic b_layer_start, b_busy, b_grant_id, b_timeout_err;
    logic signed [OUT_W-1:0] b_resp0_data, b_resp1_data;
    logic [IN_W-1:0] b_layer_input;

    logic req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_err, resp1_err;
    logic layer_start, busy, grant_id, timeout_err;
    logic [OUT_W-1:0] resp0_data, resp1_data;
    logic [IN_W-1:0] layer_input;

    disc_layer2_arbiter u_dut_a (
        .clk(clk), .rst(rst_a),
        .req0_valid(req0_valid), .req0_ready(a_req0_ready), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(a_req1_ready), .req1_data(req1_data),
        .resp0_valid(a_resp0_valid), .resp0_ready(resp0_ready), .resp0_data(a_resp0_data), .resp0_err(a_resp0_err),
        .resp1_valid(a_resp1_valid), .resp1_ready(resp1_ready), .resp1_data(a_resp1_data), .resp1_err(a_resp1_err),
        .layer_start(a_layer_start), .layer_input(a_layer_input),
        .layer_output(layer_output), .layer_done(layer_done),
        .busy(a_busy), .grant_id(a_grant_id), .timeout_err(a_timeout_err)
    );

    disc_layer2_arbiter #(.TIMEOUT_CYCLES(64)) u_dut_b (
        .clk(clk), .rst(rst_b),
        .req0_valid(req0_valid), .req0_ready(b_req0_ready), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(b_req1_ready), .req1_data(req1_data),
        .resp0_valid(b_resp0_valid), .resp0_ready(resp0_ready), .resp0_data(b_resp0_data), .resp0_err(b_resp0_err),
        .resp1_valid(b_resp1_valid), .resp1_ready(resp1_ready), .resp1_data(b_resp1_data), .resp1_err(b_resp1_err),
        .layer_start(b_layer_start), .layer_input(b_layer_input),
        .layer_output(layer_output), .layer_done(layer_done),
        .busy(b_busy), .grant_id(b_grant_id), .timeout_err(b_timeout_err)
    );

    assign req0_ready  = use_b ? b_req0_ready  : a_req0_ready;
    assign req1_ready  = use_b ? b_req1_ready  : a_req1_ready;
    assign resp0_valid = use_b ? b_resp0_valid : a_resp0_valid;
    assign resp1_valid = use_b ? b_resp1_valid : a_resp1_valid;
    assign resp0_err   = use_b ? b_resp0_err   : a_resp0_err;
    assign resp1_err   = use_b ? b_resp1_err   : a_resp1_err;
    assign resp0_data  = use_b ? b_resp0_data  : a_resp0_data;
    assign resp1_data  = use_b ? b_resp1_data  : a_resp1_data;
    assign layer_start = use_b ? b_layer_start : a_layer_start;
    assign layer_input = use_b ? b_layer_input : a_layer_input;
    assign busy        = use_b ? b_busy        : a_busy;
    assign grant_id    = use_b ? b_grant_id    : a_grant_id;
    assign timeout_err = use_b ? b_timeout_err : a_timeout_err;

    int n_checks = 0;
    int n_errors = 0;
    int start_cnt = 0;

    // Count cycles with layer_start high on the active instance.
    always @(posedge clk) begin
        if (layer_start) start_cnt <= start_cnt + 1;
    end

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Valids already driven; check the offered ready, take the handshake edge, check ISSUE.
    task automatic accept(input string tag, input bit gid);
        #1;
        check({tag, "_rdy"}, 512'({req1_ready, req0_ready}), gid ? 512'(2) : 512'(1));
        tick();
        #1;
        check({tag, "_issue"}, 512'({layer_start, busy, grant_id}), 512'({1'b1, 1'b1, gid}));
    endtask

    // Called in the ISSUE cycle s; pulses done in cycle s+after.
    task automatic wait_done(input string tag, input int after, input logic [511:0] out);
        repeat (after) tick();
        #1;
        check({tag, "_early"}, 512'({resp1_valid, resp0_valid}), 512'(0));
        layer_done   = 1'b1;
        layer_output = out;
        tick();
        layer_done = 1'b0;
        #1;
    endtask

    task automatic check_resp(input string tag, input bit gid, input logic [511:0] data, input bit err);
        check({tag, "_vld"}, 512'({resp1_valid, resp0_valid}), gid ? 512'(2) : 512'(1));
        check({tag, "_data"}, gid ? resp1_data : resp0_data, data);
        check({tag, "_err"}, 512'({resp1_err, resp0_err}), err ? (gid ? 512'(2) : 512'(1)) : 512'(0));
    endtask

    task automatic finish_resp(input string tag, input bit gid);
        if (gid) resp1_ready = 1'b1; else resp0_ready = 1'b1;
        tick();
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
        #1;
        check({tag, "_done"}, 512'({busy, resp1_valid, resp0_valid}), 512'(0));
    endtask

    logic [OUT_W-1:0] pat;
    logic [OUT_W-1:0] held;
    int sc0;

    initial begin
        use_b = 1'b0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b0;
        req0_data = '0;
        req1_data = '0;
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
        layer_done = 1'b0;
        layer_output = '0;

        // Reset values, with a valid pending that must not see ready.
        repeat (2) tick();
        #1;
        check("rst_ctrl", 512'({req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_err, resp1_err,
                                layer_start, busy, grant_id, timeout_err}), 512'(0));
        check("rst_input", 512'(layer_input != '0), 512'(0));
        check("rst_data", resp0_data | resp1_data, 512'(0));

        // Single request, engine finishes 8200 cycles after start.
        req0_valid = 1'b0;
        rst_a = 1'b0;
        tick();
        req0_data[15:0] = 16'h0100;
        req0_valid = 1'b1;
        sc0 = start_cnt;
        accept("single", 1'b0);
        req0_valid = 1'b0;
        check("single_lin", 512'(layer_input == req0_data), 512'(1));
        pat = {32{16'h1234}};
        wait_done("single", 8200, pat);
        check_resp("single", 1'b0, pat, 1'b0);
        check("single_pulses", 512'(start_cnt - sc0), 512'(1));
        finish_resp("single", 1'b0);

        // Stray done while idle.
        layer_done = 1'b1;
        tick();
        layer_done = 1'b0;
        #1;
        check("stray_a", 512'({busy, layer_start, resp1_valid, resp0_valid}), 512'(0));

        // Contention from reset release: 0, 1, 0.
        rst_a = 1'b1;
        tick();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data = IN_W'(16'h00a0);
        req1_data = IN_W'(16'h00b1);
        rst_a = 1'b0;
        accept("c1", 1'b0);
        check("c1_lin", 512'(layer_input == IN_W'(16'h00a0)), 512'(1));
        req0_data = IN_W'(16'h00a2);
        wait_done("c1", 3, 512'(16'h1111));
        check_resp("c1", 1'b0, 512'(16'h1111), 1'b0);
        finish_resp("c1", 1'b0);
        accept("c2", 1'b1);
        check("c2_lin", 512'(layer_input == IN_W'(16'h00b1)), 512'(1));
        req1_data = IN_W'(16'h00b3);
        wait_done("c2", 5, 512'(16'h2222));
        check_resp("c2", 1'b1, 512'(16'h2222), 1'b0);
        finish_resp("c2", 1'b1);
        accept("c3", 1'b0);
        check("c3_lin", 512'(layer_input == IN_W'(16'h00a2)), 512'(1));
        req0_valid = 1'b0;
        wait_done("c3", 2, 512'(16'h3333));
        check_resp("c3", 1'b0, 512'(16'h3333), 1'b0);
        finish_resp("c3", 1'b0);

        // Backpressure on requester 1 with requester 0 waiting.
        req0_valid = 1'b1;
        accept("bp", 1'b1);
        req1_valid = 1'b0;
        held = {16{32'hdead_beef}};
        wait_done("bp", 2, held);
        sc0 = start_cnt;
        for (int i = 0; i < 50; i++) begin
            check("bp_hold", 512'({resp1_valid, resp1_data == held, req0_ready, layer_start}), 512'(4'b1100));
            tick();
            #1;
        end
        check("bp_nostart", 512'(start_cnt - sc0), 512'(0));
        finish_resp("bp", 1'b1);
        accept("bp_next", 1'b0);
        req0_valid = 1'b0;
        wait_done("bp_next", 1, 512'(16'h5555));
        check_resp("bp_next", 1'b0, 512'(16'h5555), 1'b0);
        finish_resp("bp_next", 1'b0);

        // Switch to the 64-cycle timeout instance.
        rst_a = 1'b1;
        use_b = 1'b1;
        rst_b = 1'b0;
        tick();
        req0_valid = 1'b1;
        accept("b_norm", 1'b0);
        req0_valid = 1'b0;
        wait_done("b_norm", 10, 512'(16'h6666));
        check_resp("b_norm", 1'b0, 512'(16'h6666), 1'b0);
        finish_resp("b_norm", 1'b0);

        // Engine never finishes: error response after the 64th WAIT cycle.
        req0_valid = 1'b1;
        accept("to", 1'b0);
        req0_valid = 1'b0;
        repeat (64) tick();
        #1;
        check("to_early", 512'({resp0_valid, timeout_err}), 512'(0));
        tick();
        #1;
        check_resp("to", 1'b0, 512'(0), 1'b1);
        check("to_flag", 512'(timeout_err), 512'(1));
        finish_resp("to", 1'b0);
        check("to_sticky", 512'(timeout_err), 512'(1));

        req1_valid = 1'b1;
        accept("after_to", 1'b1);
        req1_valid = 1'b0;
        wait_done("after_to", 20, 512'(16'h7777));
        check_resp("after_to", 1'b1, 512'(16'h7777), 1'b0);
        check("after_to_sticky", 512'(timeout_err), 512'(1));
        finish_resp("after_to", 1'b1);

        // Done on the timeout cycle wins.
        req0_valid = 1'b1;
        accept("dat", 1'b0);
        req0_valid = 1'b0;
        wait_done("dat", 64, 512'(16'h8888));
        check_resp("dat", 1'b0, 512'(16'h8888), 1'b0);
        finish_resp("dat", 1'b0);

        layer_done = 1'b1;
        tick();
        layer_done = 1'b0;
        #1;
        check("stray_b", 512'({busy, layer_start, resp1_valid, resp0_valid}), 512'(0));

        // Reset mid-WAIT, then tie must go to requester 0 again.
        req0_valid = 1'b1;
        req0_data = IN_W'(16'h0abc);
        accept("rmw", 1'b0);
        req0_valid = 1'b0;
        repeat (10) tick();
        rst_b = 1'b1;
        #1;
        check("rmw_ctrl", 512'({req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_err, resp1_err,
                                layer_start, busy, grant_id, timeout_err}), 512'(0));
        check("rmw_input", 512'(layer_input != '0), 512'(0));
        check("rmw_data", resp0_data | resp1_data, 512'(0));
        tick();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rst_b = 1'b0;
        accept("post_rst", 1'b0);
        req0_valid = 1'b0;
        wait_done("post_rst", 4, 512'(16'h9999));
        check_resp("post_rst", 1'b0, 512'(16'h9999), 1'b0);
        finish_resp("post_rst", 1'b0);
        accept("post_rst1", 1'b1);
        req1_valid = 1'b0;
        wait_done("post_rst1", 6, 512'(16'haaaa));
        check_resp("post_rst1", 1'b1, 512'(16'haaaa), 1'b0);
        finish_resp("post_rst1", 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
